we_mem_stream: RTL

//  Weight buffer, next generation: NUM_CH consumer channels (conv kernel-1, conv kxk, ...) with a

---
 rtl/we_mem_stream.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/we_mem_stream.sv
// we_mem_stream: weight buffer with a burst read engine.
// The AXI HP side writes words into an inferred dual-port array; the channel
// selected by OPCODE starts a (base, len) burst that streams out through a small
// output FIFO on a valid/ready interface with full backpressure.
// Build option: WE_MEM_WRAP_EN -- when defined, bursts wrap past the last address;
// when undefined, bursts are truncated at the last address and err is raised.
// Stream handshake: a beat moves when rd_valid & rd_ready; once rd_valid rises,
// rd_valid and rd_data hold until that beat moves.
module we_mem_stream #(
    parameter int AXI_HP_BIT = 64,
    parameter int ADDR_WIDTH = 14,
    parameter int NUM_CH     = 3,
    parameter int LEN_WIDTH  = 10,
    parameter int RD_LAT     = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [2:0]                      OPCODE,
    input  logic                            wr_en,
    input  logic [ADDR_WIDTH-1:0]           wr_addr,
    input  logic [AXI_HP_BIT-1:0]           wr_data,
    input  logic [NUM_CH-1:0]               rd_start,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]    rd_base,
    input  logic [NUM_CH*LEN_WIDTH-1:0]     rd_len,
    output logic [AXI_HP_BIT-1:0]           rd_data,
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic                            rd_last,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);
    // Room for every read in flight plus the words already buffered.
    localparam int FIFO_DEPTH = RD_LAT + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    logic [AXI_HP_BIT-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [AXI_HP_BIT-1:0] fifo_mem [FIFO_DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;  // reads still to issue
    logic [LEN_WIDTH-1:0]  beats_q, beats_d;          // beats still to deliver
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [2:0]            count_q, count_d;

    logic                  sel_start;
    logic [ADDR_WIDTH-1:0] sel_base;
    logic [LEN_WIDTH-1:0]  sel_len;
    logic [LEN_WIDTH-1:0]  eff_len;
    logic                  trunc;
    logic                  issue, push, pop;
    logic [2:0]            in_flight;
    logic [AXI_HP_BIT-1:0] fill_data;

    // Pick the start/base/len of the channel addressed by OPCODE.
    always_comb begin
        sel_start = 1'b0;
        sel_base  = '0;
        sel_len   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(OPCODE) == i) begin
                sel_start = rd_start[i];
                sel_base  = rd_base[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len   = rd_len[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

`ifdef WE_MEM_WRAP_EN
    // Bursts wrap modulo the memory size, so the full length is always read.
    always_comb begin
        eff_len = sel_len;
        trunc   = 1'b0;
    end
`else
    localparam int CW = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;
    logic [CW-1:0] room;
    // Clip the burst to the words left before the end of memory.
    always_comb begin
        room    = CW'(1 << ADDR_WIDTH) - CW'(sel_base);
        eff_len = sel_len;
        trunc   = 1'b0;
        if (CW'(sel_len) > room) begin
            eff_len = room[LEN_WIDTH-1:0];
            trunc   = 1'b1;
        end
    end
`endif

    // Issue a read only when its word is guaranteed a FIFO slot.
    always_comb begin
        issue = (state_q == RUN) && ((count_q + in_flight) < 3'(FIFO_DEPTH));
        pop   = (count_q != 3'd0) && rd_ready;
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            // The memory read lands directly in the FIFO on the issue edge.
            always_comb begin
                push      = issue;
                fill_data = mem[addr_q];
                in_flight = 3'd0;
            end
        end else begin : g_lat2
            logic                  stage_vld_q, stage_vld_d;
            logic [AXI_HP_BIT-1:0] stage_data_q;
            // One extra read stage; its valid bit is the single read in flight.
            always_comb begin
                stage_vld_d = issue;
                push        = stage_vld_q;
                fill_data   = stage_data_q;
                in_flight   = {2'b00, stage_vld_q};
            end
            // Registered memory read; reset discards the word in flight.
            always_ff @(posedge clk) begin
                stage_data_q <= mem[addr_q];
                if (rst) stage_vld_q <= 1'b0;
                else     stage_vld_q <= stage_vld_d;
            end
        end
    endgenerate

    // Burst FSM: start decode, read issue, beat bookkeeping and done/err.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        beats_d     = beats_q;
        done_d      = 1'b0;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (sel_start) begin
                    if (sel_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = RUN;
                        addr_d      = sel_base;
                        remaining_d = eff_len;
                        beats_d     = eff_len;
                        if (trunc) err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_WIDTH'(1)) state_d = DRAIN;
                end
            end
            default: ;
        endcase
        if (pop) begin
            beats_d = beats_q - 1'b1;
            if (beats_q == LEN_WIDTH'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    // Output FIFO pointer and occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = (wr_ptr_q == 2'(FIFO_DEPTH - 1)) ? 2'd0 : wr_ptr_q + 2'd1;
        if (pop)  rd_ptr_d = (rd_ptr_q == 2'(FIFO_DEPTH - 1)) ? 2'd0 : rd_ptr_q + 2'd1;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // Control registers; reset aborts any burst and empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            beats_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            beats_q     <= beats_d;
            done_q      <= done_d;
            err_q       <= err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Write port; reads of the same address this edge still see the old word.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= fill_data;
    end

    always_comb begin
        rd_valid = (count_q != 3'd0);
        rd_data  = rd_valid ? fifo_mem[rd_ptr_q] : '0;
        rd_last  = rd_valid && (beats_q == LEN_WIDTH'(1));
        busy     = (state_q != IDLE);
        done     = done_q;
        err      = err_q;
    end
endmodule
